// File: rtl/riscv_mmio_ctrl_if.sv
// CPU load/store access bus and UART byte streams of the Riscv150 MMIO controller.
interface riscv_mmio_ctrl_if;
    logic        stall;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        inst_retired;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    modport master (
        output stall, addr, wdata, we, re, inst_retired,
        output uart_rx_data, uart_rx_valid, uart_tx_ready,
        input  rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
    );

    modport slave (
        input  stall, addr, wdata, we, re, inst_retired,
        input  uart_rx_data, uart_rx_valid, uart_tx_ready,
        output rdata, uart_rx_ready, uart_tx_data, uart_tx_valid
    );
endinterface

// File: rtl/riscv_mmio_ctrl.sv
// MMIO controller: 0x8000_00xx register window, UART RX/TX FIFOs, cycle and instret counters.
// Load data is registered so it arrives in the writeback stage alongside dmem data.
module riscv_mmio_ctrl #(
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned CNT_W    = 32
) (
    input logic              clk,
    input logic              rst,
    riscv_mmio_ctrl_if.slave bus
);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam logic [RxAw:0] RxMax = (RxAw + 1)'(RX_DEPTH);
    localparam logic [TxAw:0] TxMax = (TxAw + 1)'(TX_DEPTH);

    localparam logic [7:0] OffStatus = 8'h00;
    localparam logic [7:0] OffRxData = 8'h04;
    localparam logic [7:0] OffTxData = 8'h08;
    localparam logic [7:0] OffCycle  = 8'h10;
    localparam logic [7:0] OffInstr  = 8'h14;
    localparam logic [7:0] OffCntClr = 8'h18;
    localparam logic [7:0] OffFifo   = 8'h1C;

    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RxAw-1:0] rx_wptr_q, rx_rptr_q;
    logic [RxAw:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TxAw-1:0] tx_wptr_q, tx_rptr_q;
    logic [TxAw:0]   tx_cnt_q, tx_cnt_d;
    logic            rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
    logic [31:0]     rdata_q, rdata_d, rd_val;

    logic sel, acc, st, ld, rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_pop, rx_rd, tx_req, tx_push, tx_pop, tx_drop, ovf_clr, cnt_clr;

    // A simultaneous load and store counts as a store only.
    assign sel = bus.addr[31:8] == 24'h800000;
    assign acc = (bus.re || (|bus.we)) && !bus.stall;
    assign st  = (|bus.we) && !bus.stall && sel;
    assign ld  = bus.re && !(|bus.we) && !bus.stall && sel;

    assign rx_empty = rx_cnt_q == '0;
    assign rx_full  = rx_cnt_q == RxMax;
    assign tx_empty = tx_cnt_q == '0;
    assign tx_full  = tx_cnt_q == TxMax;

    assign rx_push = bus.uart_rx_valid && !rx_full;
    assign rx_rd   = ld && (bus.addr[7:0] == OffRxData);
    assign rx_pop  = rx_rd && !rx_empty;

    // A store into a full TX FIFO is kept only if the UART drains an entry the same cycle.
    assign tx_pop  = !tx_empty && bus.uart_tx_ready;
    assign tx_req  = st && (bus.addr[7:0] == OffTxData) && bus.we[0];
    assign tx_push = tx_req && (!tx_full || tx_pop);
    assign tx_drop = tx_req && tx_full && !tx_pop;

    assign ovf_clr = st && (bus.addr[7:0] == OffFifo);
    assign cnt_clr = st && (bus.addr[7:0] == OffCntClr);

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + (RxAw + 1)'(1);
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (RxAw + 1)'(1);
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (TxAw + 1)'(1);
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (TxAw + 1)'(1);

        // Sticky set beats a same-cycle clear.
        rx_ovf_d = (rx_rd && rx_empty) ? 1'b1 : (ovf_clr ? 1'b0 : rx_ovf_q);
        tx_ovf_d = tx_drop ? 1'b1 : (ovf_clr ? 1'b0 : tx_ovf_q);

        cycle_d = cnt_clr ? '0 : cycle_q + CNT_W'(1);
        instr_d = instr_q;
        if (cnt_clr) instr_d = '0;
        else if (bus.inst_retired && !bus.stall) instr_d = instr_q + CNT_W'(1);
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr[7:0])
            OffStatus: rd_val = {30'b0, !rx_empty, !tx_full};
            OffRxData: rd_val = {24'b0, rx_empty ? 8'h00 : rx_mem[rx_rptr_q]};
            OffCycle:  rd_val = 32'(cycle_q);
            OffInstr:  rd_val = 32'(instr_q);
            OffFifo:   rd_val = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 6'b0, rx_ovf_q, tx_ovf_q};
            default:   rd_val = '0;
        endcase
        rdata_d = rdata_q;
        if (acc) rdata_d = ld ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= bus.uart_rx_data;
        if (tx_push) tx_mem[tx_wptr_q] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + RxAw'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxAw'(1);
            if (tx_push) tx_wptr_q <= tx_wptr_q + TxAw'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxAw'(1);
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_ovf_q <= rx_ovf_d;
            tx_ovf_q <= tx_ovf_d;
            cycle_q  <= cycle_d;
            instr_q  <= instr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata         = rdata_q;
    assign bus.uart_rx_ready = !rx_full;
    assign bus.uart_tx_valid = !tx_empty;
    assign bus.uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr_q];
endmodule

// File: tb/tb_riscv_mmio_ctrl.sv
// Self-checking bench for riscv_mmio_ctrl: load results go through an expected-value queue.
module tb_riscv_mmio_ctrl;
    localparam logic [31:0] Base = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    logic [31:0] sb_q[$];
    string       tag_q[$];

    riscv_mmio_ctrl_if m ();
    riscv_mmio_ctrl_if b ();

    riscv_mmio_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    riscv_mmio_ctrl #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; then compare any load result that became due on that edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) check_eq(tag_q.pop_front(), m.rdata, sb_q.pop_front());
    endtask

    task automatic load(input logic [7:0] off, input logic [31:0] exp, input string tag);
        m.addr = Base | 32'(off);
        m.re   = 1'b1;
        m.we   = 4'h0;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        cyc();
        m.re = 1'b0;
    endtask

    task automatic store(input logic [7:0] off, input logic [31:0] data);
        m.addr  = Base | 32'(off);
        m.wdata = data;
        m.we    = 4'hF;
        cyc();
        m.we = 4'h0;
    endtask

    task automatic rx_push(input logic [7:0] data);
        m.uart_rx_data  = data;
        m.uart_rx_valid = 1'b1;
        cyc();
        m.uart_rx_valid = 1'b0;
    endtask

    initial begin
        {m.stall, m.addr, m.wdata, m.we, m.re, m.inst_retired} = '0;
        {m.uart_rx_data, m.uart_rx_valid, m.uart_tx_ready} = '0;
        {b.stall, b.addr, b.wdata, b.we, b.re, b.inst_retired} = '0;
        {b.uart_rx_data, b.uart_rx_valid, b.uart_tx_ready} = '0;

        cyc();
        cyc();
        rst = 1'b0;
        check_eq("rst_rdata", m.rdata, 32'h0);
        check_eq("rst_tx_valid", 32'(m.uart_tx_valid), 32'h0);
        check_eq("rst_rx_ready", 32'(m.uart_rx_ready), 32'h1);
        check_eq("rst_tx_data", 32'(m.uart_tx_data), 32'h0);

        load(8'h00, 32'h1, "status_after_rst");

        // TX streaming with the UART always ready
        m.uart_tx_ready = 1'b1;
        store(8'h08, 32'h41);
        check_eq("tx_first", {23'b0, m.uart_tx_valid, m.uart_tx_data}, 32'h141);
        store(8'h08, 32'h42);
        check_eq("tx_second", {23'b0, m.uart_tx_valid, m.uart_tx_data}, 32'h142);
        cyc();
        check_eq("tx_drained", 32'(m.uart_tx_valid), 32'h0);
        m.uart_tx_ready = 1'b0;

        // RX fill to full, refused push, pop, full push+pop
        for (int i = 0; i < 8; i++) rx_push(8'(8'h10 + i));
        check_eq("rx_full_ready", 32'(m.uart_rx_ready), 32'h0);
        rx_push(8'hEE);
        load(8'h1C, 32'h0008_0000, "fifo_rx_full");
        load(8'h00, 32'h3, "status_rx_full");
        load(8'h04, 32'h10, "rx_pop_first");
        check_eq("rx_ready_after_pop", 32'(m.uart_rx_ready), 32'h1);
        rx_push(8'h18);
        check_eq("rx_full_again", 32'(m.uart_rx_ready), 32'h0);
        m.uart_rx_data  = 8'h19;
        m.uart_rx_valid = 1'b1;
        load(8'h04, 32'h11, "rx_pop_while_full");
        m.uart_rx_valid = 1'b0;
        check_eq("rx_ready_after_full_pop", 32'(m.uart_rx_ready), 32'h1);
        for (int i = 0; i < 7; i++) load(8'h04, 32'(8'h12 + i), "rx_drain");
        load(8'h1C, 32'h0, "fifo_rx_empty");

        // TX full, dropped store, sticky flags
        for (int i = 0; i < 8; i++) store(8'h08, 32'(8'h60 + i));
        load(8'h00, 32'h0, "status_tx_full");
        store(8'h08, 32'h55);
        load(8'h1C, 32'h0000_0801, "tx_ovf_set");
        store(8'h1C, 32'h0);
        load(8'h1C, 32'h0000_0800, "tx_ovf_clr");
        load(8'h04, 32'h0, "rx_underflow_data");
        load(8'h1C, 32'h0000_0802, "rx_ovf_set");
        m.uart_tx_ready = 1'b1;
        store(8'h08, 32'h68);
        m.uart_tx_ready = 1'b0;
        check_eq("tx_full_push_pop_head", 32'(m.uart_tx_data), 32'h61);
        load(8'h1C, 32'h0000_0802, "tx_full_push_pop_nodrop");
        store(8'h1C, 32'h0);
        m.uart_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("tx_drain", {23'b0, m.uart_tx_valid, m.uart_tx_data}, 32'(9'h100 + 9'h61 + i));
            cyc();
        end
        m.uart_tx_ready = 1'b0;
        check_eq("tx_drain_done", 32'(m.uart_tx_valid), 32'h0);
        load(8'h1C, 32'h0, "fifo_all_clear");

        // Counters
        store(8'h18, 32'h0);
        for (int i = 0; i < 20; i++) begin
            m.inst_retired = (i < 7);
            m.stall        = (i < 2);
            cyc();
        end
        m.inst_retired = 1'b0;
        m.stall        = 1'b0;
        load(8'h10, 32'd20, "cycle_count");
        load(8'h14, 32'd5, "instr_count");
        store(8'h18, 32'h0);
        load(8'h10, 32'h0, "cycle_cleared");
        load(8'h14, 32'h0, "instr_cleared");

        // Stalled load has no side effect and holds rdata
        rx_push(8'hA5);
        load(8'h00, 32'h3, "status_one_rx");
        m.stall = 1'b1;
        load(8'h04, 32'h3, "stalled_load_hold");
        m.stall = 1'b0;
        load(8'h1C, 32'h0001_0000, "stalled_no_pop");
        load(8'h04, 32'hA5, "rx_after_stall");

        // Reset while a TX byte is pending
        store(8'h08, 32'h77);
        check_eq("tx_pending", 32'(m.uart_tx_valid), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("midrst_tx_valid", 32'(m.uart_tx_valid), 32'h0);
        check_eq("midrst_rdata", m.rdata, 32'h0);
        load(8'h1C, 32'h0, "midrst_fifo");

        // Narrow counter wraps
        check_eq("cnt4_rst_rdata", b.rdata, 32'h0);
        rst4 = 1'b0;
        for (int i = 0; i < 17; i++) cyc();
        b.addr = Base | 32'h10;
        b.re   = 1'b1;
        cyc();
        b.re = 1'b0;
        check_eq("cnt4_wrap", b.rdata, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
